// File: rtl/cajero_secuenciador.sv
// Session sequencer for the automatic cashier: card -> PIN -> one transaction -> back to idle.
// Owns the account balance and reports dispense, rejection, timeout and card-lock events.
module cajero_secuenciador #(
  parameter int ANCHO_MONTO                       = 32,
  parameter int ANCHO_BALANCE                     = 64,
  parameter logic [ANCHO_BALANCE-1:0] BALANCE_INICIAL = 1000,
  parameter int TIMEOUT_CICLOS                    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tarjeta_recibida,
  input  logic                     digito_stb,
  input  logic                     pin_fin,
  input  logic                     pin_incorrecto,
  input  logic                     pin_bloqueo,
  input  logic                     monto_stb,
  input  logic                     tipo_trans,
  input  logic [ANCHO_MONTO-1:0]   monto,
  output logic                     pin_habilitar,
  output logic [ANCHO_BALANCE-1:0] balance,
  output logic                     balance_actualizado,
  output logic                     entregar_dinero,
  output logic                     fondos_insuficientes,
  output logic                     sesion_cancelada,
  output logic                     bloqueo_tarjeta,
  output logic                     fin
);

  localparam int CW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CW-1:0] CUENTA_MAX = CW'(TIMEOUT_CICLOS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ESPERA_PIN,
    ESPERA_MONTO,
    EJECUTAR,
    BLOQUEADO
  } estado_t;

  estado_t                    state_reg, state_next;
  logic [CW-1:0]              cuenta_reg, cuenta_next;
  logic                       tipo_reg, tipo_next;
  logic [ANCHO_MONTO-1:0]     monto_reg, monto_next;
  logic [ANCHO_BALANCE-1:0]   balance_reg, balance_next;
  logic                       actualizado_reg, actualizado_next;
  logic                       entregar_reg, entregar_next;
  logic                       fondos_reg, fondos_next;
  logic                       cancelada_reg, cancelada_next;
  logic                       fin_reg, fin_next;
  logic                       pin_hab_reg;
  logic                       bloqueo_reg;

  logic [ANCHO_BALANCE-1:0]   monto_ext;
  logic [ANCHO_BALANCE:0]     suma;
  logic                       timeout;

  assign monto_ext = ANCHO_BALANCE'(monto_reg);
  assign suma      = {1'b0, balance_reg} + {1'b0, monto_ext};
  assign timeout   = (cuenta_reg == CUENTA_MAX);

  always_comb begin
    state_next       = state_reg;
    cuenta_next      = cuenta_reg;
    tipo_next        = tipo_reg;
    monto_next       = monto_reg;
    balance_next     = balance_reg;
    actualizado_next = 1'b0;
    entregar_next    = 1'b0;
    fondos_next      = 1'b0;
    cancelada_next   = 1'b0;
    fin_next         = 1'b0;

    case (state_reg)
      IDLE: begin
        cuenta_next = '0;
        if (tarjeta_recibida) state_next = ESPERA_PIN;
      end

      ESPERA_PIN: begin
        if (pin_bloqueo) begin
          state_next  = BLOQUEADO;
          cuenta_next = '0;
        end else if (pin_fin) begin
          state_next  = ESPERA_MONTO;
          cuenta_next = '0;
        end else if (digito_stb || pin_incorrecto) begin
          // Keypad activity in the firing cycle still rescues the session.
          cuenta_next = '0;
        end else if (timeout) begin
          state_next     = IDLE;
          cancelada_next = 1'b1;
          cuenta_next    = '0;
        end else begin
          cuenta_next = cuenta_reg + CW'(1);
        end
      end

      ESPERA_MONTO: begin
        if (monto_stb) begin
          state_next  = EJECUTAR;
          tipo_next   = tipo_trans;
          monto_next  = monto;
          cuenta_next = '0;
        end else if (digito_stb || pin_incorrecto) begin
          cuenta_next = '0;
        end else if (timeout) begin
          state_next     = IDLE;
          cancelada_next = 1'b1;
          cuenta_next    = '0;
        end else begin
          cuenta_next = cuenta_reg + CW'(1);
        end
      end

      EJECUTAR: begin
        state_next = IDLE;
        fin_next   = 1'b1;
        if (!tipo_reg) begin
          // Deposits saturate rather than wrap the balance.
          balance_next     = suma[ANCHO_BALANCE] ? '1 : suma[ANCHO_BALANCE-1:0];
          actualizado_next = 1'b1;
        end else if (monto_ext <= balance_reg) begin
          balance_next     = balance_reg - monto_ext;
          actualizado_next = 1'b1;
          entregar_next    = 1'b1;
        end else begin
          fondos_next = 1'b1;
        end
      end

      BLOQUEADO: state_next = BLOQUEADO;

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      cuenta_reg      <= '0;
      tipo_reg        <= 1'b0;
      monto_reg       <= '0;
      balance_reg     <= BALANCE_INICIAL;
      actualizado_reg <= 1'b0;
      entregar_reg    <= 1'b0;
      fondos_reg      <= 1'b0;
      cancelada_reg   <= 1'b0;
      fin_reg         <= 1'b0;
      pin_hab_reg     <= 1'b0;
      bloqueo_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cuenta_reg      <= cuenta_next;
      tipo_reg        <= tipo_next;
      monto_reg       <= monto_next;
      balance_reg     <= balance_next;
      actualizado_reg <= actualizado_next;
      entregar_reg    <= entregar_next;
      fondos_reg      <= fondos_next;
      cancelada_reg   <= cancelada_next;
      fin_reg         <= fin_next;
      // Level outputs are registered from the next state so they track the state exactly.
      pin_hab_reg     <= (state_next == ESPERA_PIN);
      bloqueo_reg     <= (state_next == BLOQUEADO);
    end
  end

  assign pin_habilitar        = pin_hab_reg;
  assign balance              = balance_reg;
  assign balance_actualizado  = actualizado_reg;
  assign entregar_dinero      = entregar_reg;
  assign fondos_insuficientes = fondos_reg;
  assign sesion_cancelada     = cancelada_reg;
  assign bloqueo_tarjeta      = bloqueo_reg;
  assign fin                  = fin_reg;

endmodule

// File: tb/tb_cajero_secuenciador.sv
// Directed bench for cajero_secuenciador: transactions, saturation, timeouts, lock and reset.
// A second instance preloaded near the top of the balance range covers deposit saturation.
module tb_cajero_secuenciador;

  logic        clk = 1'b0;
  logic        reset;
  logic        tarjeta_recibida, tarjeta_b;
  logic        digito_stb, pin_fin, pin_incorrecto, pin_bloqueo;
  logic        monto_stb, tipo_trans;
  logic [31:0] monto;

  logic        pin_habilitar, balance_actualizado, entregar_dinero;
  logic        fondos_insuficientes, sesion_cancelada, bloqueo_tarjeta, fin;
  logic [63:0] balance;

  logic        s_pin_habilitar, s_balance_actualizado, s_entregar_dinero;
  logic        s_fondos_insuficientes, s_sesion_cancelada, s_bloqueo_tarjeta, s_fin;
  logic [63:0] s_balance;

  int checks = 0;
  int errors = 0;
  logic vio_cancel;

  always #5 clk = ~clk;

  cajero_secuenciador u_dut (
    .clk(clk), .reset(reset), .tarjeta_recibida(tarjeta_recibida),
    .digito_stb(digito_stb), .pin_fin(pin_fin), .pin_incorrecto(pin_incorrecto),
    .pin_bloqueo(pin_bloqueo), .monto_stb(monto_stb), .tipo_trans(tipo_trans),
    .monto(monto), .pin_habilitar(pin_habilitar), .balance(balance),
    .balance_actualizado(balance_actualizado), .entregar_dinero(entregar_dinero),
    .fondos_insuficientes(fondos_insuficientes), .sesion_cancelada(sesion_cancelada),
    .bloqueo_tarjeta(bloqueo_tarjeta), .fin(fin)
  );

  cajero_secuenciador #(.BALANCE_INICIAL(64'hFFFF_FFFF_FFFF_FFF0)) u_sat (
    .clk(clk), .reset(reset), .tarjeta_recibida(tarjeta_b),
    .digito_stb(digito_stb), .pin_fin(pin_fin), .pin_incorrecto(pin_incorrecto),
    .pin_bloqueo(pin_bloqueo), .monto_stb(monto_stb), .tipo_trans(tipo_trans),
    .monto(monto), .pin_habilitar(s_pin_habilitar), .balance(s_balance),
    .balance_actualizado(s_balance_actualizado), .entregar_dinero(s_entregar_dinero),
    .fondos_insuficientes(s_fondos_insuficientes), .sesion_cancelada(s_sesion_cancelada),
    .bloqueo_tarjeta(s_bloqueo_tarjeta), .fin(s_fin)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Card, correct PIN, one amount; returns just after the edge that shows the result pulses.
  task automatic sesion(input logic usar_b, input logic tipo, input logic [31:0] m);
    if (usar_b) tarjeta_b = 1'b1; else tarjeta_recibida = 1'b1;
    tick();
    tarjeta_b = 1'b0; tarjeta_recibida = 1'b0;
    pin_fin = 1'b1;
    tick();
    pin_fin = 1'b0;
    monto_stb = 1'b1; tipo_trans = tipo; monto = m;
    tick();
    monto_stb = 1'b0; monto = '0;
    tick();
  endtask

  initial begin
    reset = 1'b1; tarjeta_recibida = 0; tarjeta_b = 0; digito_stb = 0; pin_fin = 0;
    pin_incorrecto = 0; pin_bloqueo = 0; monto_stb = 0; tipo_trans = 0; monto = '0;
    tick(); tick();
    chk("reset_balance", balance, 64'd1000);
    chk("reset_flags", {pin_habilitar, balance_actualizado, entregar_dinero,
        fondos_insuficientes, sesion_cancelada, bloqueo_tarjeta, fin}, 64'd0);
    reset = 1'b0;
    tick();

    // T1: withdrawal 300, checking latency step by step
    tarjeta_recibida = 1'b1; tick(); tarjeta_recibida = 1'b0;
    chk("t1_pin_hab_on", pin_habilitar, 1);
    pin_fin = 1'b1; tick(); pin_fin = 1'b0;
    chk("t1_pin_hab_off", pin_habilitar, 0);
    monto_stb = 1'b1; tipo_trans = 1'b1; monto = 32'd300; tick(); monto_stb = 1'b0;
    chk("t1_no_early_pulse", {entregar_dinero, fin}, 0);
    chk("t1_balance_before", balance, 64'd1000);
    tick();
    chk("t1_pulses", {balance_actualizado, entregar_dinero, fondos_insuficientes, fin}, 4'b1101);
    chk("t1_balance", balance, 64'd700);
    tick();
    chk("t1_pulses_gone", {balance_actualizado, entregar_dinero, fin}, 0);
    chk("t1_balance_hold", balance, 64'd700);
    $display("T1 withdrawal 300 -> balance %0d", balance);

    // T2: insufficient funds
    sesion(1'b0, 1'b1, 32'd701);
    chk("t2_pulses", {balance_actualizado, entregar_dinero, fondos_insuficientes, fin}, 4'b0011);
    chk("t2_balance", balance, 64'd700);
    tick();
    chk("t2_pulses_gone", {fondos_insuficientes, fin}, 0);
    $display("T2 withdrawal 701 rejected, balance %0d", balance);

    // Zero deposit is legal and still reported as a balance update
    sesion(1'b0, 1'b0, 32'd0);
    chk("zero_dep_pulses", {balance_actualizado, entregar_dinero, fin}, 3'b101);
    chk("zero_dep_balance", balance, 64'd700);
    tick();
    $display("deposit 0 -> balance %0d", balance);

    // T3: saturation on the preloaded instance; main instance stays idle
    sesion(1'b1, 1'b0, 32'h20);
    chk("t3_sat_balance", s_balance, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_sat_pulses", {s_balance_actualizado, s_fin}, 2'b11);
    chk("t3_main_idle", {balance, fin}, {64'd700, 1'b0});
    tick();
    $display("T3 deposit 0x20 -> saturated balance %0h", s_balance);

    // T4: PIN timeout after 16 quiet cycles
    tarjeta_recibida = 1'b1; tick(); tarjeta_recibida = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("t4_no_cancel_15", {pin_habilitar, sesion_cancelada}, 2'b10);
    tick();
    chk("t4_cancel", {pin_habilitar, sesion_cancelada}, 2'b01);
    tick();
    chk("t4_cancel_pulse", sesion_cancelada, 0);
    $display("T4 PIN timeout -> session cancelled");

    // T4b: digit activity every 10 cycles keeps the session alive
    tarjeta_recibida = 1'b1; tick(); tarjeta_recibida = 1'b0;
    vio_cancel = 1'b0;
    for (int i = 0; i < 40; i++) begin
      digito_stb = (i % 10 == 9);
      tick();
      if (sesion_cancelada) vio_cancel = 1'b1;
    end
    digito_stb = 1'b0;
    chk("t4b_no_cancel", vio_cancel, 0);
    chk("t4b_still_pin", pin_habilitar, 1);
    $display("T4b digit activity -> no timeout over 40 cycles");

    // Amount-wait timeout
    pin_fin = 1'b1; tick(); pin_fin = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("monto_no_cancel_15", sesion_cancelada, 0);
    tick();
    chk("monto_cancel", sesion_cancelada, 1);
    tick();
    $display("amount wait timeout -> session cancelled");

    // T5: wrong attempts, then lock wins over pin_fin
    tarjeta_recibida = 1'b1; tick(); tarjeta_recibida = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pin_incorrecto = 1'b1; tick(); pin_incorrecto = 1'b0; tick();
    end
    chk("t5_after_wrong", {pin_habilitar, bloqueo_tarjeta}, 2'b10);
    pin_bloqueo = 1'b1; pin_fin = 1'b1; tick(); pin_bloqueo = 1'b0; pin_fin = 1'b0;
    chk("t5_locked", {pin_habilitar, bloqueo_tarjeta}, 2'b01);
    tarjeta_recibida = 1'b1; monto_stb = 1'b1; tick(); tick(); tick();
    tarjeta_recibida = 1'b0; monto_stb = 1'b0;
    chk("t5_lock_held", {pin_habilitar, bloqueo_tarjeta, fin}, 3'b010);
    reset = 1'b1; #1;
    chk("t5_reset_unlock", {bloqueo_tarjeta, balance}, {1'b0, 64'd1000});
    tick(); reset = 1'b0; tick();
    $display("T5 card locked, cleared by reset");

    // T6: reset between amount strobe and execution discards the transaction
    sesion(1'b0, 1'b0, 32'd50);
    chk("t6_deposit", balance, 64'd1050);
    tick();
    tarjeta_recibida = 1'b1; tick(); tarjeta_recibida = 1'b0;
    pin_fin = 1'b1; tick(); pin_fin = 1'b0;
    monto_stb = 1'b1; tipo_trans = 1'b1; monto = 32'd100; tick(); monto_stb = 1'b0;
    reset = 1'b1; #1;
    chk("t6_async_balance", balance, 64'd1000);
    tick(); reset = 1'b0; tick();
    chk("t6_no_pulses", {balance_actualizado, entregar_dinero, fondos_insuficientes, fin}, 0);
    chk("t6_balance", balance, 64'd1000);
    sesion(1'b0, 1'b1, 32'd100);
    chk("t6_after_reset_wd", {entregar_dinero, balance}, {1'b1, 64'd900});
    tick();
    $display("T6 reset mid-transaction -> balance %0d after fresh withdrawal", balance);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
